// File: rtl/alarm_setter_pkg.sv
// Shared clock-system constants for the alarm editor: field codes, FSM
// states, live-bus slice positions, field limits and BCD conversion.
package alarm_setter_pkg;

  // edit_field encodings
  localparam logic [2:0] FLD_YEAR = 3'd0;
  localparam logic [2:0] FLD_MON  = 3'd1;
  localparam logic [2:0] FLD_DAY  = 3'd2;
  localparam logic [2:0] FLD_HOUR = 3'd3;
  localparam logic [2:0] FLD_MIN  = 3'd4;
  localparam logic [2:0] FLD_SEC  = 3'd5;
  localparam logic [2:0] FLD_IDLE = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_E_YEAR = 3'd1,
    S_E_MON  = 3'd2,
    S_E_DAY  = 3'd3,
    S_E_HOUR = 3'd4,
    S_E_MIN  = 3'd5,
    S_E_SEC  = 3'd6,
    S_COMMIT = 3'd7
  } state_t;

  // bin_date = {year[22:10], month[9:6], spare[5], day[4:0]}
  localparam int DATE_YEAR_MSB  = 22;
  localparam int DATE_YEAR_LSB  = 10;
  localparam int DATE_MON_MSB   = 9;
  localparam int DATE_MON_LSB   = 6;
  localparam int DATE_DAY_MSB   = 4;
  localparam int DATE_DAY_LSB   = 0;
  // bin_watch = {hour[16:12], min[11:6], sec[5:0]}
  localparam int WATCH_HOUR_MSB = 16;
  localparam int WATCH_HOUR_LSB = 12;
  localparam int WATCH_MIN_MSB  = 11;
  localparam int WATCH_MIN_LSB  = 6;
  localparam int WATCH_SEC_MSB  = 5;
  localparam int WATCH_SEC_LSB  = 0;

  localparam logic [3:0] MON_MAX  = 4'd12;
  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MS_MAX   = 6'd59;

  // Field shown on edit_field for a given state; COMMIT reads as idle.
  function automatic logic [2:0] field_of(input state_t s);
    case (s)
      S_E_YEAR: return FLD_YEAR;
      S_E_MON:  return FLD_MON;
      S_E_DAY:  return FLD_DAY;
      S_E_HOUR: return FLD_HOUR;
      S_E_MIN:  return FLD_MIN;
      S_E_SEC:  return FLD_SEC;
      default:  return FLD_IDLE;
    endcase
  endfunction

  // Shift-add-3 binary to 4-digit BCD; inputs above 9999 never occur here.
  function automatic logic [15:0] bin2bcd(input logic [13:0] bin);
    logic [15:0] bcd;
    bcd = '0;
    for (int i = 13; i >= 0; i--) begin
      for (int d = 0; d < 4; d++) begin
        if (bcd[d*4 +: 4] >= 4'd5) bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
      bcd = {bcd[14:0], bin[i]};
    end
    return bcd;
  endfunction

endpackage

// File: rtl/alarm_setter_dim.sv
// Days-in-month lookup; February is 29 whenever year%4==0 (valid 2000-2099).
module alarm_dim (
  input  logic [3:0]  month,
  input  logic [13:0] year,
  output logic [4:0]  dim
);
  // Month-length table with the simple leap rule.
  always_comb begin
    case (month)
      4'd2:                     dim = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  dim = 5'd30;
      default:                  dim = 5'd31;
    endcase
  end
endmodule

// File: rtl/alarm_setter.sv
// Alarm time editor: seeds from the live buses, steps fields with wrap and
// calendar clamping, and commits all six BCD save_* fields on one edge.
module alarm_setter
  import alarm_setter_pkg::*;
#(
  parameter int          YEAR_MIN    = 2000,
  parameter int          YEAR_MAX    = 2099,
  parameter logic [31:0] TIMEOUT_CYC = 32'd500_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_ok,
  input  logic        btn_cancel,
  input  logic        alarm_clear,
  input  logic [22:0] bin_date,
  input  logic [16:0] bin_watch,
  output logic [15:0] save_year,
  output logic [7:0]  save_mon,
  output logic [7:0]  save_day,
  output logic [7:0]  save_hour,
  output logic [7:0]  save_min,
  output logic [7:0]  save_sec,
  output logic        save_valid,
  output logic        armed,
  output logic        editing,
  output logic [2:0]  edit_field
);
  localparam logic [13:0] YMIN = 14'(YEAR_MIN);
  localparam logic [13:0] YMAX = 14'(YEAR_MAX);

  state_t      state, state_nxt;
  logic [13:0] ed_year, year_nxt, cand_year;
  logic [3:0]  ed_mon, mon_nxt, cand_mon;
  logic [4:0]  ed_day, day_nxt, cand_dim;
  logic [4:0]  ed_hour, hour_nxt;
  logic [5:0]  ed_min, min_nxt;
  logic [5:0]  ed_sec, sec_nxt;
  logic [31:0] tmo_cnt, cnt_nxt;

  // Raw live-bus fields and their sanitised seed values
  logic [13:0] raw_year, seed_year;
  logic [3:0]  raw_mon, seed_mon;
  logic [4:0]  raw_day, seed_day, raw_hour, seed_hour;
  logic [5:0]  raw_min, raw_sec, seed_min, seed_sec;

  assign raw_year = {1'b0, bin_date[DATE_YEAR_MSB:DATE_YEAR_LSB]};
  assign raw_mon  = bin_date[DATE_MON_MSB:DATE_MON_LSB];
  assign raw_day  = bin_date[DATE_DAY_MSB:DATE_DAY_LSB];
  assign raw_hour = bin_watch[WATCH_HOUR_MSB:WATCH_HOUR_LSB];
  assign raw_min  = bin_watch[WATCH_MIN_MSB:WATCH_MIN_LSB];
  assign raw_sec  = bin_watch[WATCH_SEC_MSB:WATCH_SEC_LSB];

  assign seed_year = (raw_year < YMIN || raw_year > YMAX) ? YMIN : raw_year;
  assign seed_mon  = (raw_mon == 4'd0 || raw_mon > MON_MAX) ? 4'd1 : raw_mon;
  assign seed_day  = (raw_day == 5'd0) ? 5'd1 :
                     (raw_day > cand_dim) ? cand_dim : raw_day;
  assign seed_hour = (raw_hour > HOUR_MAX) ? 5'd0 : raw_hour;
  assign seed_min  = (raw_min > MS_MAX) ? 6'd0 : raw_min;
  assign seed_sec  = (raw_sec > MS_MAX) ? 6'd0 : raw_sec;

  // A step only happens when no higher-priority button is present.
  logic in_edit, step_en, step_up, step_dn, tmo_hit;
  assign in_edit = state inside {S_E_YEAR, S_E_MON, S_E_DAY, S_E_HOUR, S_E_MIN, S_E_SEC};
  assign step_en = in_edit & ~btn_cancel & ~btn_ok & ~btn_mode;
  assign step_up = step_en & btn_up & ~btn_down;
  assign step_dn = step_en & btn_down & ~btn_up;
  assign tmo_hit = (tmo_cnt == TIMEOUT_CYC - 32'd1);

  // Candidate year/month for this edge; the day clamp is judged against these.
  always_comb begin
    cand_year = ed_year;
    cand_mon  = ed_mon;
    if (state == S_IDLE) begin
      cand_year = seed_year;
      cand_mon  = seed_mon;
    end else if (state == S_E_YEAR && step_up) begin
      cand_year = (ed_year >= YMAX) ? YMIN : ed_year + 14'd1;
    end else if (state == S_E_YEAR && step_dn) begin
      cand_year = (ed_year <= YMIN) ? YMAX : ed_year - 14'd1;
    end else if (state == S_E_MON && step_up) begin
      cand_mon = (ed_mon >= MON_MAX) ? 4'd1 : ed_mon + 4'd1;
    end else if (state == S_E_MON && step_dn) begin
      cand_mon = (ed_mon <= 4'd1) ? MON_MAX : ed_mon - 4'd1;
    end
  end

  alarm_dim u_dim (
    .month (cand_mon),
    .year  (cand_year),
    .dim   (cand_dim)
  );

  // Next-state, edit-buffer and idle-timeout decode with button priority.
  always_comb begin
    state_nxt = state;
    year_nxt  = ed_year;
    mon_nxt   = ed_mon;
    day_nxt   = ed_day;
    hour_nxt  = ed_hour;
    min_nxt   = ed_min;
    sec_nxt   = ed_sec;
    cnt_nxt   = '0;
    case (state)
      S_IDLE: begin
        if (btn_mode) begin
          state_nxt = S_E_YEAR;
          year_nxt  = cand_year;
          mon_nxt   = cand_mon;
          day_nxt   = seed_day;
          hour_nxt  = seed_hour;
          min_nxt   = seed_min;
          sec_nxt   = seed_sec;
        end
      end
      S_COMMIT: state_nxt = S_IDLE;
      default: begin
        if (btn_cancel)    state_nxt = S_IDLE;
        else if (btn_ok)   state_nxt = S_COMMIT;
        else if (btn_mode) state_nxt = (state == S_E_SEC) ? S_E_YEAR : state_t'(state + 3'd1);
        else if (btn_up || btn_down) begin
          year_nxt = cand_year;
          mon_nxt  = cand_mon;
          day_nxt  = (ed_day > cand_dim) ? cand_dim : ed_day;
          if (state == S_E_DAY && step_up) day_nxt = (ed_day >= cand_dim) ? 5'd1 : ed_day + 5'd1;
          if (state == S_E_DAY && step_dn) day_nxt = (ed_day <= 5'd1) ? cand_dim : ed_day - 5'd1;
          if (state == S_E_HOUR && step_up) hour_nxt = (ed_hour >= HOUR_MAX) ? 5'd0 : ed_hour + 5'd1;
          if (state == S_E_HOUR && step_dn) hour_nxt = (ed_hour == 5'd0) ? HOUR_MAX : ed_hour - 5'd1;
          if (state == S_E_MIN && step_up) min_nxt = (ed_min >= MS_MAX) ? 6'd0 : ed_min + 6'd1;
          if (state == S_E_MIN && step_dn) min_nxt = (ed_min == 6'd0) ? MS_MAX : ed_min - 6'd1;
          if (state == S_E_SEC && step_up) sec_nxt = (ed_sec >= MS_MAX) ? 6'd0 : ed_sec + 6'd1;
          if (state == S_E_SEC && step_dn) sec_nxt = (ed_sec == 6'd0) ? MS_MAX : ed_sec - 6'd1;
        end
        else if (tmo_hit)  state_nxt = S_IDLE;
        else               cnt_nxt = tmo_cnt + 32'd1;
      end
    endcase
  end

  // BCD images of the edit buffer, captured into save_* at commit
  logic [15:0] bcd_year, bcd_mon, bcd_day, bcd_hour, bcd_min, bcd_sec;
  assign bcd_year = bin2bcd(ed_year);
  assign bcd_mon  = bin2bcd({10'd0, ed_mon});
  assign bcd_day  = bin2bcd({9'd0, ed_day});
  assign bcd_hour = bin2bcd({9'd0, ed_hour});
  assign bcd_min  = bin2bcd({8'd0, ed_min});
  assign bcd_sec  = bin2bcd({8'd0, ed_sec});

  logic unused_bits;
  assign unused_bits = &{1'b0, bin_date[5], bcd_mon[15:8], bcd_day[15:8],
                         bcd_hour[15:8], bcd_min[15:8], bcd_sec[15:8]};

  // State, edit buffer, timeout and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      ed_year    <= YMIN;
      ed_mon     <= 4'd1;
      ed_day     <= 5'd1;
      ed_hour    <= 5'd0;
      ed_min     <= 6'd0;
      ed_sec     <= 6'd0;
      tmo_cnt    <= '0;
      save_year  <= '0;
      save_mon   <= '0;
      save_day   <= '0;
      save_hour  <= '0;
      save_min   <= '0;
      save_sec   <= '0;
      save_valid <= 1'b0;
      armed      <= 1'b0;
      editing    <= 1'b0;
      edit_field <= FLD_IDLE;
    end else begin
      state      <= state_nxt;
      ed_year    <= year_nxt;
      ed_mon     <= mon_nxt;
      ed_day     <= day_nxt;
      ed_hour    <= hour_nxt;
      ed_min     <= min_nxt;
      ed_sec     <= sec_nxt;
      tmo_cnt    <= cnt_nxt;
      editing    <= state_nxt inside {S_E_YEAR, S_E_MON, S_E_DAY, S_E_HOUR, S_E_MIN, S_E_SEC};
      edit_field <= field_of(state_nxt);
      save_valid <= (state == S_COMMIT);
      if (state == S_COMMIT) begin
        save_year <= bcd_year;
        save_mon  <= bcd_mon[7:0];
        save_day  <= bcd_day[7:0];
        save_hour <= bcd_hour[7:0];
        save_min  <= bcd_min[7:0];
        save_sec  <= bcd_sec[7:0];
        armed     <= 1'b1;
      end else if (alarm_clear) begin
        armed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alarm_setter.sv
// Bench for alarm_setter: scenario tasks drive buttons, a negedge monitor
// pops expected save_* records whenever save_valid pulses.
module tb_alarm_setter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_ok = 1'b0, btn_cancel = 1'b0;
  logic        alarm_clear = 1'b0;
  logic [22:0] bin_date = '0;
  logic [16:0] bin_watch = '0;
  logic [15:0] save_year;
  logic [7:0]  save_mon, save_day, save_hour, save_min, save_sec;
  logic        save_valid, armed, editing;
  logic [2:0]  edit_field;

  int tests_run = 0;
  int fails = 0;
  logic [55:0] exp_q[$];
  logic [55:0] last_saved = '0;
  logic [55:0] obs;

  localparam logic [4:0] B_CANCEL = 5'b10000;
  localparam logic [4:0] B_OK     = 5'b01000;
  localparam logic [4:0] B_MODE   = 5'b00100;
  localparam logic [4:0] B_UP     = 5'b00010;
  localparam logic [4:0] B_DOWN   = 5'b00001;

  assign obs = {save_year, save_mon, save_day, save_hour, save_min, save_sec};

  alarm_setter #(.TIMEOUT_CYC(32'd16)) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .btn_ok(btn_ok), .btn_cancel(btn_cancel), .alarm_clear(alarm_clear),
    .bin_date(bin_date), .bin_watch(bin_watch),
    .save_year(save_year), .save_mon(save_mon), .save_day(save_day),
    .save_hour(save_hour), .save_min(save_min), .save_sec(save_sec),
    .save_valid(save_valid), .armed(armed), .editing(editing), .edit_field(edit_field)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [55:0] exp_rec(input int y, input int m, input int d,
                                          input int h, input int mi, input int s);
    logic [15:0] by;
    by = {4'(y / 1000), 4'((y / 100) % 10), 4'((y / 10) % 10), 4'(y % 10)};
    return {by, bcd2(m), bcd2(d), bcd2(h), bcd2(mi), bcd2(s)};
  endfunction

  function automatic logic [22:0] mk_date(input int y, input int m, input int d);
    return {13'(y), 4'(m), 1'b0, 5'(d)};
  endfunction

  function automatic logic [16:0] mk_watch(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] b);
    {btn_cancel, btn_ok, btn_mode, btn_up, btn_down} = b;
    tick();
    {btn_cancel, btn_ok, btn_mode, btn_up, btn_down} = '0;
  endtask

  // ok from an edit state: COMMIT for one cycle, then save_* land together.
  task automatic do_commit(input logic [55:0] e, input string name);
    exp_q.push_back(e);
    press(B_OK);
    tests_run++;
    if (edit_field !== 3'd7 || save_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_commit_state: edit_field=%0d save_valid=%b, required 7 and 0", name, edit_field, save_valid);
    end
    tick();
    tests_run++;
    if (armed !== 1'b1) begin
      fails++;
      $display("FAIL %s_armed: got %b, required 1", name, armed);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_no_save_valid: %0d record(s) not produced", name, exp_q.size());
      exp_q.delete();
    end
    last_saved = e;
    tick();
    tests_run++;
    if (save_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_valid_width: save_valid=%b two cycles after commit, required 0", name, save_valid);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst && save_valid) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL spurious_save_valid: save=%h with nothing expected", obs);
      end else begin
        logic [55:0] e;
        e = exp_q.pop_front();
        if (obs !== e) begin
          fails++;
          $display("FAIL save_fields: got %h, required %h", obs, e);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    tests_run++;
    if (obs !== 56'd0 || save_valid !== 1'b0 || armed !== 1'b0 || editing !== 1'b0 || edit_field !== 3'd7) begin
      fails++;
      $display("FAIL reset_outputs: save=%h sv=%b armed=%b editing=%b field=%0d, required 0/0/0/0/7",
               obs, save_valid, armed, editing, edit_field);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_seed_commit();
    bin_date  = mk_date(2024, 2, 29);
    bin_watch = mk_watch(23, 59, 58);
    press(B_MODE);
    tests_run++;
    if (editing !== 1'b1 || edit_field !== 3'd0) begin
      fails++;
      $display("FAIL seed_enter_edit: editing=%b field=%0d, required 1 and 0", editing, edit_field);
    end
    do_commit(exp_rec(2024, 2, 29, 23, 59, 58), "seed");
  endtask

  task automatic test_clamp();
    // Year step out of a leap year pulls Feb 29 down to 28.
    press(B_MODE);
    press(B_UP);
    tests_run++;
    if (edit_field !== 3'd0) begin
      fails++;
      $display("FAIL clamp_field: got %0d, required 0", edit_field);
    end
    do_commit(exp_rec(2025, 2, 28, 23, 59, 58), "clamp_year");
    // Month step from March 31 to February clamps to 28.
    bin_date = mk_date(2023, 3, 31);
    press(B_MODE);
    press(B_MODE);
    press(B_DOWN);
    do_commit(exp_rec(2023, 2, 28, 23, 59, 58), "clamp_mon");
  endtask

  task automatic test_wrap();
    bin_date  = mk_date(2099, 1, 31);
    bin_watch = mk_watch(23, 0, 0);
    press(B_MODE);
    press(B_UP);     // 2099 -> 2000
    press(B_MODE);
    press(B_DOWN);   // month 1 -> 12, day 31 kept
    press(B_MODE);
    tests_run++;
    if (edit_field !== 3'd2) begin
      fails++;
      $display("FAIL wrap_field_day: got %0d, required 2", edit_field);
    end
    press(B_UP);     // 31 -> 1
    press(B_DOWN);   // 1 -> 31
    press(B_MODE);
    press(B_UP);     // 23 -> 0
    press(B_MODE);
    press(B_DOWN);   // min 0 -> 59
    press(B_MODE);
    press(B_DOWN);   // sec 0 -> 59
    press(B_MODE);   // E_SEC wraps to E_YEAR
    tests_run++;
    if (edit_field !== 3'd0) begin
      fails++;
      $display("FAIL wrap_field_sec_to_year: got %0d, required 0", edit_field);
    end
    do_commit(exp_rec(2000, 12, 31, 0, 59, 59), "wrap");
  endtask

  task automatic test_same_cycle();
    press(B_MODE);
    press(B_CANCEL | B_OK);
    tests_run++;
    if (editing !== 1'b0 || edit_field !== 3'd7 || obs !== last_saved) begin
      fails++;
      $display("FAIL cancel_beats_ok: editing=%b field=%0d save=%h, required 0/7/%h",
               editing, edit_field, obs, last_saved);
    end
    tick();
    tick();
    tests_run++;
    if (save_valid !== 1'b0 || obs !== last_saved) begin
      fails++;
      $display("FAIL cancel_no_commit: sv=%b save=%h, required 0 and %h", save_valid, obs, last_saved);
    end
    press(B_MODE);
    press(B_UP | B_DOWN);
    do_commit(exp_rec(2099, 1, 31, 23, 0, 0), "up_down_same");
  endtask

  task automatic test_timeout();
    press(B_MODE);
    repeat (15) tick();
    tests_run++;
    if (editing !== 1'b1) begin
      fails++;
      $display("FAIL timeout_early: editing=%b after 15 idle cycles, required 1", editing);
    end
    tick();
    tests_run++;
    if (editing !== 1'b0 || edit_field !== 3'd7 || obs !== last_saved) begin
      fails++;
      $display("FAIL timeout_exit: editing=%b field=%0d save=%h, required 0/7/%h",
               editing, edit_field, obs, last_saved);
    end
    press(B_MODE);
    repeat (9) tick();
    press(B_MODE);   // pulse at cycle 10 restarts the count
    repeat (15) tick();
    tests_run++;
    if (editing !== 1'b1 || edit_field !== 3'd1) begin
      fails++;
      $display("FAIL timeout_restart_hold: editing=%b field=%0d, required 1 and 1", editing, edit_field);
    end
    tick();
    tests_run++;
    if (editing !== 1'b0) begin
      fails++;
      $display("FAIL timeout_restart_exit: editing=%b, required 0", editing);
    end
  endtask

  task automatic test_alarm_clear();
    alarm_clear = 1'b1;
    tick();
    alarm_clear = 1'b0;
    tests_run++;
    if (armed !== 1'b0 || obs !== last_saved) begin
      fails++;
      $display("FAIL clear_disarm: armed=%b save=%h, required 0 and %h", armed, obs, last_saved);
    end
    // Commit and clear on the same edge: commit wins.
    bin_date  = mk_date(2030, 6, 15);
    bin_watch = mk_watch(7, 8, 9);
    press(B_MODE);
    exp_q.push_back(exp_rec(2030, 6, 15, 7, 8, 9));
    press(B_OK);
    alarm_clear = 1'b1;
    tick();
    alarm_clear = 1'b0;
    tests_run++;
    if (armed !== 1'b1) begin
      fails++;
      $display("FAIL clear_vs_commit: armed=%b, required 1", armed);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL clear_vs_commit_save: %0d record(s) not produced", exp_q.size());
      exp_q.delete();
    end
    last_saved = exp_rec(2030, 6, 15, 7, 8, 9);
    tick();
  endtask

  task automatic test_sanitise();
    bin_date  = {13'd1999, 4'd13, 1'b0, 5'd0};
    bin_watch = {5'd24, 6'd60, 6'd60};
    press(B_MODE);
    do_commit(exp_rec(2000, 1, 1, 0, 0, 0), "seed_out_of_range");
    bin_date  = mk_date(2023, 2, 30);
    bin_watch = mk_watch(12, 34, 56);
    press(B_MODE);
    do_commit(exp_rec(2023, 2, 28, 12, 34, 56), "seed_day_over_dim");
    bin_date  = mk_date(2100, 4, 31);
    bin_watch = mk_watch(0, 0, 0);
    press(B_MODE);
    do_commit(exp_rec(2000, 4, 30, 0, 0, 0), "seed_year_2100");
  endtask

  task automatic test_reset_mid_edit();
    press(B_MODE);
    press(B_MODE);
    press(B_MODE);
    tests_run++;
    if (edit_field !== 3'd2) begin
      fails++;
      $display("FAIL mid_edit_field: got %0d, required 2", edit_field);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (obs !== 56'd0 || save_valid !== 1'b0 || armed !== 1'b0 || editing !== 1'b0 || edit_field !== 3'd7) begin
      fails++;
      $display("FAIL mid_edit_reset: save=%h sv=%b armed=%b editing=%b field=%0d, required 0/0/0/0/7",
               obs, save_valid, armed, editing, edit_field);
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if (editing !== 1'b0 || edit_field !== 3'd7) begin
      fails++;
      $display("FAIL after_reset_idle: editing=%b field=%0d, required 0 and 7", editing, edit_field);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_seed_commit();
    test_clamp();
    test_wrap();
    test_same_cycle();
    test_timeout();
    test_alarm_clear();
    test_sanitise();
    test_reset_mid_edit();
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d record(s) left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/alarm_setter.md
Name: alarm_setter

Overview:
- User-facing editor that produces the stored alarm time consumed by the alarm comparator: save_year/mon/day/hour/min/sec in BCD.
- Driven by debounced single-cycle button pulses.
- Seeds the edit buffer from the live calendar/watch binary buses.
- Steps through the fields with range-correct wrap and calendar clamping, then commits atomically or discards.

Parameters:
- YEAR_MIN, 2000, lowest editable year (binary).
- YEAR_MAX, 2099, highest editable year (binary); leap rule is year%4==0 within this range.
- TIMEOUT_CYC, 32'd500_000_000, idle-edit cycles before an automatic cancel.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- btn_mode  in  1  pulse: enter edit / advance field
- btn_up  in  1  pulse: increment current field
- btn_down  in  1  pulse: decrement current field
- btn_ok  in  1  pulse: commit
- btn_cancel  in  1  pulse: abort edit
- alarm_clear  in  1  level/pulse: disarm alarm
- bin_date  in  23  live date: year[22:10], month[9:6], day[4:0]
- bin_watch  in  17  live time: hour[16:12], min[11:6], sec[5:0]
- save_year  out  16  BCD year, 4 digits
- save_mon  out  8  BCD month
- save_day  out  8  BCD day
- save_hour  out  8  BCD hour
- save_min  out  8  BCD minute
- save_sec  out  8  BCD second
- save_valid  out  1  one-cycle pulse when save_* update
- armed  out  1  alarm stored and active
- editing  out  1  high in any EDIT state
- edit_field  out  3  0=year,1=mon,2=day,3=hour,4=min,5=sec,7=idle

Behaviour:
Reset (rst==0 at posedge):
- save_* = 0, save_valid=0, armed=0, editing=0, edit_field=7, state IDLE.
- Edit regs: YEAR_MIN/1/1/0/0/0.
- Timeout counter 0.

States: IDLE, E_YEAR, E_MON, E_DAY, E_HOUR, E_MIN, E_SEC, COMMIT.

Per-cycle button priority: cancel > ok > mode > up/down. up&down together: no change.

IDLE:
- btn_mode: load edit regs from bin_date/bin_watch, go to E_YEAR.
- On that load, year outside [YEAR_MIN,YEAR_MAX] -> YEAR_MIN; month 0 or >12 -> 1; day 0 -> 1, day > dim -> dim; hour>23, min>59, sec>59 -> 0.
- Other buttons are ignored in IDLE.

E_x (any edit state):
- btn_mode advances to the next field; E_SEC wraps to E_YEAR.
- btn_up / btn_down step the current field by ±1 with wrap:
  - year: YEAR_MAX<->YEAR_MIN
  - month: 12<->1
  - day: dim<->1
  - hour: 23<->0
  - min, sec: 59<->0
- dim(month, year): 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; February is 29 if year%4==0, else 28.
- When year or month changes, day is clamped to the new dim in the same edge.
- btn_ok goes to COMMIT.
- btn_cancel, or the timeout counter reaching TIMEOUT_CYC-1, goes to IDLE with save_*/armed unchanged.
- The timeout counter clears on any button pulse and on entering edit; it counts only in E_x states.

COMMIT (exactly 1 cycle):
- On the edge leaving COMMIT: save_* <= BCD(edit regs), save_valid<=1 for that one cycle, armed<=1, go to IDLE.
- Latency: btn_ok at edge N -> save_* valid and save_valid high after edge N+1.

Field update rule:
- All six save_* fields update on the same edge; never partially.

alarm_clear:
- armed<=0 in any state; save_* retained.
- alarm_clear in COMMIT: commit wins (armed=1).

Reset mid-edit: returns to the reset state; buffered edits are lost.

Outputs:
- editing and edit_field are registered and follow the state.
- save_valid is 0 except in the cycle after COMMIT.

Decomposition:
Shared package (clock-system constants):
- Field encodings (FLD_YEAR..FLD_SEC, FLD_IDLE=7).
- State encoding.
- Bit-slice positions of bin_date/bin_watch.
- Limit constants 12/23/59.

Sub-module:
- alarm_dim: combinational days-in-month from (month[3:0], year[13:0]) -> dim[4:0]. Used for stepping, clamping and seed sanitising.
- BCD conversion reuses the existing bin2bcd: widths 14/4/5/5/6/6, digits 4/2/2/2/2/2, fed from the edit regs and registered into save_* at commit.

Test Plan:
- Reset, then mode; seed bin_date = 2024/02/29 and bin_watch = 23:59:58; ok -> after 2 edges save_year=16'h2024, save_mon=8'h02, save_day=8'h29, save_hour=8'h23, save_min=8'h59, save_sec=8'h58, save_valid one pulse, armed=1.
- Edit year 2024, day 29, month 2; advance to E_YEAR, up -> year 2025, day clamps to 28; ok -> save_day=8'h28.
- Wrap: E_HOUR at 23, up -> 0; E_MIN at 0, down -> 59; E_YEAR at 2099, up -> 2000; E_MON at 1, down -> 12, day 31 stays 31.
- Same cycle: btn_cancel & btn_ok -> IDLE, save_* unchanged, no save_valid. Separately, up & down together -> field unchanged.
- Timeout: set TIMEOUT_CYC=16, enter edit with no buttons -> IDLE after 16 cycles, editing=0, save_* unchanged. A button pulse at cycle 10 restarts the count.
- Control edges: alarm_clear while armed -> armed=0, save_* retained. rst low mid-edit (E_DAY) -> IDLE, all outputs at reset values next edge.
